command_parse_multi_tbl: RTL
============================

// Module: command_parse_multi_tbl
// PURPOSE
// - Parametrised command parser: decodes TSMP write/read commands into NUM_TBL table RAM ports plus a scalar config register bank.
// - Returns read-acks through a latency-matched pipeline; optionally NACKs bad reads.
// - Sits between the TSMP decapsulator and per-module table RAMs in the NIC datapath.
// PARAMETERS
// - DATA_W      152              payload width; CMD_W = DATA_W+52
// - NUM_TBL     2                table channels; table i has module id TBL_MID_BASE+i
// - TBL_MID_BASE 8'hd            module id of table 0
// - TBL_AW      8                RAM address width per table
// - TBL_DEPTHS  {32'd256,32'd32} packed 32b depth per table; entry 0 in bits [31:0]
// - NUM_REG     3                regulation regs at addr 32'hC+k, 9b each
// - RAM_RD_LAT  2                table RAM read latency, cycles (>=1)
// PORTS
// - i_clk               in   1                   clock
// - i_rst               in   1                   sync reset, active-high
// - iv_wr_command       in   CMD_W               write command
// - i_wr_command_wr     in   1                   write command valid
// - iv_rd_command       in   CMD_W               read command
// - i_rd_command_wr     in   1                   read command valid
// - ov_rd_ack_command   out  CMD_W               read ack / nack
// - o_rd_ack_wr         out  1                   ack valid, 1-cycle pulse
// - ov_cfg_finish       out  2                   cfg state reg, module 0 addr 3
// - ov_regulation_value out  NUM_REG*9           regulation regs, module 0 addr C+k
// - ov_tbl_wdata        out  NUM_TBL*DATA_W      table write data
// - ov_tbl_addr         out  NUM_TBL*TBL_AW      table address, shared rd/wr
// - ov_tbl_wr           out  NUM_TBL             table write strobe
// - ov_tbl_rd           out  NUM_TBL             table read strobe
// - iv_tbl_rdata        in   NUM_TBL*DATA_W      table read data
// BEHAVIOUR
// - Fields: [CMD_W-1:196] echo, [195:188] mid, [187:184] type (1 wr, 2 rd, 6 ack, 7 nack), [183:152] addr, [DATA_W-1:0] data.
// - Reset: all outputs, regs and pipeline 0; i_rst mid-flight drops in-flight reads, no ack emitted.
// - Write (valid, type 1), registered, 1 cycle:
//   - mid 0: addr 3 loads cfg_finish<=data[1:0]; addr C+k loads reg k<=data[8:0]; other addrs ignored.
//   - mid TBL_MID_BASE+i with addr < depth_i: tbl_wr[i]=1, wdata, addr[TBL_AW-1:0] for 1 cycle; else no strobe.
// - Read (valid, type 2): cycle T accepted; tbl_rd[i]/addr driven cycle T+1; ack registered, valid at T+2+RAM_RD_LAT.
//   - Register reads use the same pipeline, so ack order = command order.
//   - Register value is sampled at the ack-build cycle.
// - Fully pipelined: one read per cycle, no backpressure.
// - Ack: echo+mid+addr from the delayed command, type 6, data zero-extended.
// - tbl_wr and tbl_rd for the same table in the same cycle: write owns ov_tbl_addr; read is dropped, and NACKed when the NACK feature is enabled.
// - Write and read paths are otherwise independent and may fire in the same cycle.
// - Unused address/data bits are driven 0 whenever no strobe is active.
// CONFIGURATION
// - CMD_PARSE_NACK_EN defined: invalid reads produce a nack with the same latency: type 7, data 0.
//   - Invalid = unknown mid, addr >= depth, unmapped reg addr, or dropped read.
// - CMD_PARSE_NACK_EN undefined: invalid reads produce no ack (o_rd_ack_wr stays 0).
// STRUCTURE
// - Shared header cmd_parse_defs.vh: type codes, field bit offsets, module id 0, reg addr constants.
// - Sub-module cmd_rd_ack_pipe: RAM_RD_LAT+1 stage shift of {valid, kind, tbl idx, cmd header}.
// TESTING
// - Reset, then wr mid0 addr C data 9'h1A5 -> reg0=1A5 next cycle; rd addr C -> ack type 6 data 1A5 at T+4 (LAT=2).
// - wr mid D addr 5 data X -> tbl_wr[0] 1 cycle, addr 5; rd mid D addr 5 -> tbl_rd[0] at T+1, ack data X at T+4.
// - Back-to-back reads on 4 consecutive cycles, mixed tbl0/tbl1/reg -> 4 consecutive acks in order, correct data.
// - rd mid D addr 32 (depth 32) -> NACK_EN: type 7 at T+4; otherwise no ack.
// - Same-cycle wr+rd to tbl1 addr 7 -> write performed, read dropped/nacked.
// - Assert i_rst the cycle after 2 reads -> no acks emitted; all outputs 0.

Source files
------------

// File: rtl/command_parse_multi_tbl_pkg.sv
// rtl/command_parse_multi_tbl_pkg.sv - TSMP field layout, type codes and register map for the command parser
package command_parse_multi_tbl_pkg;

  localparam logic [3:0] TYPE_WR   = 4'd1;
  localparam logic [3:0] TYPE_RD   = 4'd2;
  localparam logic [3:0] TYPE_ACK  = 4'd6;
  localparam logic [3:0] TYPE_NACK = 4'd7;

  // Header field offsets are relative to the top of the data field
  localparam int ADDR_W   = 32;
  localparam int MID_W    = 8;
  localparam int ECHO_W   = 8;
  localparam int OFS_ADDR = 0;
  localparam int OFS_TYPE = 32;
  localparam int OFS_MID  = 36;
  localparam int OFS_ECHO = 44;
  localparam int HDR_W    = ECHO_W + MID_W + ADDR_W;

  localparam logic [7:0]  MID_CFG         = 8'h00;
  localparam logic [31:0] ADDR_CFG_FINISH = 32'h3;
  localparam logic [31:0] ADDR_REG_BASE   = 32'hC;
  localparam int          REG_W           = 9;

  typedef enum logic [1:0] {
    KIND_BAD = 2'd0,
    KIND_TBL = 2'd1,
    KIND_REG = 2'd2
  } rd_kind_e;

endpackage

// File: rtl/cmd_rd_ack_pipe.sv
// rtl/cmd_rd_ack_pipe.sv - fixed-depth shift of decoded read context, aligned with table RAM latency
module cmd_rd_ack_pipe #(
  parameter int W     = 8,
  parameter int DEPTH = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] iv_din,
  output logic [W-1:0] ov_dout
);

  logic [W-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < DEPTH; s++) r_stage[s] <= '0;
    end else begin
      r_stage[0] <= iv_din;
      for (int s = 1; s < DEPTH; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  assign ov_dout = r_stage[DEPTH-1];

endmodule

// File: rtl/command_parse_multi_tbl.sv
// rtl/command_parse_multi_tbl.sv - TSMP command parser for NUM_TBL table RAMs plus config register bank
// Define CMD_PARSE_NACK_EN to answer invalid or dropped reads with a type-7 nack.
module command_parse_multi_tbl
  import command_parse_multi_tbl_pkg::*;
#(
  parameter int                    DATA_W       = 152,
  parameter int                    NUM_TBL      = 2,
  parameter logic [7:0]            TBL_MID_BASE = 8'hd,
  parameter int                    TBL_AW       = 8,
  parameter logic [NUM_TBL*32-1:0] TBL_DEPTHS   = {32'd256, 32'd32},
  parameter int                    NUM_REG      = 3,
  parameter int                    RAM_RD_LAT   = 2,
  localparam int                   CMD_W        = DATA_W + 52
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [CMD_W-1:0]            iv_wr_command,
  input  logic                        i_wr_command_wr,
  input  logic [CMD_W-1:0]            iv_rd_command,
  input  logic                        i_rd_command_wr,
  output logic [CMD_W-1:0]            ov_rd_ack_command,
  output logic                        o_rd_ack_wr,
  output logic [1:0]                  ov_cfg_finish,
  output logic [NUM_REG*REG_W-1:0]    ov_regulation_value,
  output logic [NUM_TBL*DATA_W-1:0]   ov_tbl_wdata,
  output logic [NUM_TBL*TBL_AW-1:0]   ov_tbl_addr,
  output logic [NUM_TBL-1:0]          ov_tbl_wr,
  output logic [NUM_TBL-1:0]          ov_tbl_rd,
  input  logic [NUM_TBL*DATA_W-1:0]   iv_tbl_rdata
);

  localparam int IDX_W  = (NUM_TBL > 1) ? $clog2(NUM_TBL) : 1;
  localparam int PIPE_W = 1 + 2 + IDX_W + HDR_W;

  logic [MID_W-1:0]  w_wr_mid, w_rd_mid;
  logic [3:0]        w_wr_type, w_rd_type;
  logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [HDR_W-1:0]  w_rd_hdr;
  logic              w_wr_en, w_rd_en, w_rd_reg;
  logic [NUM_TBL-1:0] w_wr_hit, w_rd_hit, w_rd_go;
  logic [IDX_W-1:0]  w_rd_idx;
  rd_kind_e          w_rd_kind;
  logic              w_unused;

  assign w_wr_mid  = iv_wr_command[DATA_W+OFS_MID +: MID_W];
  assign w_wr_type = iv_wr_command[DATA_W+OFS_TYPE +: 4];
  assign w_wr_addr = iv_wr_command[DATA_W+OFS_ADDR +: ADDR_W];
  assign w_wr_data = iv_wr_command[DATA_W-1:0];
  assign w_rd_mid  = iv_rd_command[DATA_W+OFS_MID +: MID_W];
  assign w_rd_type = iv_rd_command[DATA_W+OFS_TYPE +: 4];
  assign w_rd_addr = iv_rd_command[DATA_W+OFS_ADDR +: ADDR_W];
  assign w_rd_hdr  = {iv_rd_command[DATA_W+OFS_MID +: ECHO_W+MID_W], w_rd_addr};
  assign w_unused  = ^{iv_wr_command[DATA_W+OFS_ECHO +: ECHO_W], iv_rd_command[DATA_W-1:0]};

  assign w_wr_en = i_wr_command_wr && (w_wr_type == TYPE_WR);
  assign w_rd_en = i_rd_command_wr && (w_rd_type == TYPE_RD);

  always_comb begin
    w_wr_hit = '0;
    w_rd_hit = '0;
    w_rd_idx = '0;
    for (int i = 0; i < NUM_TBL; i++) begin
      if (w_wr_en && (w_wr_mid == TBL_MID_BASE + 8'(i)) && (w_wr_addr < TBL_DEPTHS[i*32 +: 32]))
        w_wr_hit[i] = 1'b1;
      if (w_rd_en && (w_rd_mid == TBL_MID_BASE + 8'(i)) && (w_rd_addr < TBL_DEPTHS[i*32 +: 32])) begin
        w_rd_hit[i] = 1'b1;
        w_rd_idx    = IDX_W'(i);
      end
    end
  end

  // A write to the same table owns the shared address port, so the read loses
  assign w_rd_go  = w_rd_hit & ~w_wr_hit;
  assign w_rd_reg = w_rd_en && (w_rd_mid == MID_CFG) &&
                    ((w_rd_addr == ADDR_CFG_FINISH) ||
                     ((w_rd_addr >= ADDR_REG_BASE) && (w_rd_addr < ADDR_REG_BASE + 32'(NUM_REG))));

  always_comb begin
    w_rd_kind = KIND_BAD;
    if (|w_rd_go)     w_rd_kind = KIND_TBL;
    else if (w_rd_reg) w_rd_kind = KIND_REG;
  end

  logic [NUM_TBL*DATA_W-1:0] r_tbl_wdata;
  logic [NUM_TBL*TBL_AW-1:0] r_tbl_addr;
  logic [NUM_TBL-1:0]        r_tbl_wr, r_tbl_rd;
  logic [1:0]                r_cfg_finish;
  logic [NUM_REG*REG_W-1:0]  r_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tbl_wdata  <= '0;
      r_tbl_addr   <= '0;
      r_tbl_wr     <= '0;
      r_tbl_rd     <= '0;
      r_cfg_finish <= '0;
      r_reg        <= '0;
    end else begin
      r_tbl_wr <= w_wr_hit;
      r_tbl_rd <= w_rd_go;
      for (int i = 0; i < NUM_TBL; i++) begin
        r_tbl_wdata[i*DATA_W +: DATA_W] <= w_wr_hit[i] ? w_wr_data : '0;
        if (w_wr_hit[i])     r_tbl_addr[i*TBL_AW +: TBL_AW] <= w_wr_addr[TBL_AW-1:0];
        else if (w_rd_go[i]) r_tbl_addr[i*TBL_AW +: TBL_AW] <= w_rd_addr[TBL_AW-1:0];
        else                 r_tbl_addr[i*TBL_AW +: TBL_AW] <= '0;
      end
      if (w_wr_en && (w_wr_mid == MID_CFG)) begin
        if (w_wr_addr == ADDR_CFG_FINISH) r_cfg_finish <= w_wr_data[1:0];
        for (int k = 0; k < NUM_REG; k++)
          if (w_wr_addr == ADDR_REG_BASE + 32'(k)) r_reg[k*REG_W +: REG_W] <= w_wr_data[REG_W-1:0];
      end
    end
  end

  logic [PIPE_W-1:0] w_pipe_d, w_pipe_q;

  assign w_pipe_d = {w_rd_en, w_rd_kind, w_rd_idx, w_rd_hdr};

  cmd_rd_ack_pipe #(
    .W     (PIPE_W),
    .DEPTH (RAM_RD_LAT + 1)
  ) u_rd_ack_pipe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .iv_din  (w_pipe_d),
    .ov_dout (w_pipe_q)
  );

  logic              w_q_valid, w_ack_ok, w_ack_fire;
  rd_kind_e          w_q_kind;
  logic [IDX_W-1:0]  w_q_idx;
  logic [HDR_W-1:0]  w_q_hdr;
  logic [ADDR_W-1:0] w_q_addr;
  logic [DATA_W-1:0] w_ack_data;

  assign w_q_valid = w_pipe_q[PIPE_W-1];
  assign w_q_kind  = rd_kind_e'(w_pipe_q[PIPE_W-2 -: 2]);
  assign w_q_idx   = w_pipe_q[HDR_W +: IDX_W];
  assign w_q_hdr   = w_pipe_q[HDR_W-1:0];
  assign w_q_addr  = w_q_hdr[ADDR_W-1:0];

  // Register values are taken here, at ack-build time, not when the read was accepted
  always_comb begin
    w_ack_ok   = 1'b0;
    w_ack_data = '0;
    case (w_q_kind)
      KIND_TBL: begin
        w_ack_ok = 1'b1;
        for (int i = 0; i < NUM_TBL; i++)
          if (w_q_idx == IDX_W'(i)) w_ack_data = iv_tbl_rdata[i*DATA_W +: DATA_W];
      end
      KIND_REG: begin
        w_ack_ok = 1'b1;
        if (w_q_addr == ADDR_CFG_FINISH) w_ack_data = DATA_W'(r_cfg_finish);
        for (int k = 0; k < NUM_REG; k++)
          if (w_q_addr == ADDR_REG_BASE + 32'(k)) w_ack_data = DATA_W'(r_reg[k*REG_W +: REG_W]);
      end
      default: ;
    endcase
  end

`ifdef CMD_PARSE_NACK_EN
  assign w_ack_fire = w_q_valid;
`else
  assign w_ack_fire = w_q_valid && w_ack_ok;
`endif

  logic [CMD_W-1:0] r_ack_cmd;
  logic             r_ack_wr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack_cmd <= '0;
      r_ack_wr  <= 1'b0;
    end else begin
      r_ack_wr  <= w_ack_fire;
      r_ack_cmd <= w_ack_fire ? {w_q_hdr[HDR_W-1:ADDR_W], (w_ack_ok ? TYPE_ACK : TYPE_NACK),
                                 w_q_addr, w_ack_data} : '0;
    end
  end

  assign ov_rd_ack_command   = r_ack_cmd;
  assign o_rd_ack_wr         = r_ack_wr;
  assign ov_cfg_finish       = r_cfg_finish;
  assign ov_regulation_value = r_reg;
  assign ov_tbl_wdata        = r_tbl_wdata;
  assign ov_tbl_addr         = r_tbl_addr;
  assign ov_tbl_wr           = r_tbl_wr;
  assign ov_tbl_rd           = r_tbl_rd;

endmodule
